demux2_buf: RTL and testbench

- Registered 1-to-2 demultiplexer: the write-side counterpart of mux2_1.
- Takes a single 32-bit data stream with a valid/ready handshake and routes each word to channel A or channel B, selected per word by a select bit.
- Each output channel has a one-entry holding register, so a stalled channel does not block words bound for the other channel.
- Sits between pipeline producers (ALU/load results) and independent consumers.

---
 rtl/demux2_buf_pkg.sv | 15 +
 rtl/demux_slot.sv | 74 +++++++
 rtl/demux2_buf.sv | 65 ++++++
 tb/tb_demux2_buf.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux2_buf_pkg.sv
// Shared pipeline definitions for the registered 1-to-2 demultiplexer.
// Holds the default data width, the select encoding and the slot state type.
package demux2_buf_pkg;

   localparam int XLEN = 32;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding slot with valid/ready drain and a saturating
// count of delivered words; can_accept tells the top a load may land now.
module demux_slot
   import demux2_buf_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt,
   output logic             can_accept
);

   slot_state_e      state_p0;
   slot_state_e      state_nxt;
   logic [WIDTH-1:0] data_p0;
   logic [CNT_W-1:0] cnt_p0;
   logic             drain;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign valid      = (state_p0 == SLOT_FULL);
   assign drain      = valid && ready;
   assign can_accept = !valid || ready;
   assign data       = data_p0;
   assign cnt        = cnt_p0;

   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
         SLOT_FULL:  if (drain && !load) state_nxt = SLOT_EMPTY;
         default:    state_nxt = SLOT_EMPTY;
      endcase
   end

   // stage p0: slot state, held word and delivery counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0 <= SLOT_EMPTY;
      end else begin
         state_p0 <= state_nxt;
      end
   end

   // The word is only overwritten by a load; a plain drain leaves it visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p0 <= '0;
      end else if (load) begin
         data_p0 <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p0 <= '0;
      end else if (drain) begin
         cnt_p0 <= sat_inc(cnt_p0);
      end
   end

endmodule

// File: rtl/demux2_buf.sv
// Registered 1-to-2 demultiplexer: routes each accepted word to channel A or B
// by in_sel, each channel buffered by its own one-entry slot.
module demux2_buf
   import demux2_buf_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   logic a_can;
   logic b_can;
   logic load_a;
   logic load_b;

   // Only the selected channel gates acceptance, so a stalled peer never blocks.
   assign in_ready = (in_sel == SEL_A) ? a_can : b_can;
   assign load_a   = in_valid && in_ready && (in_sel == SEL_A);
   assign load_b   = in_valid && in_ready && (in_sel == SEL_B);

   demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_a),
      .load_data  (in_data),
      .ready      (a_ready),
      .valid      (a_valid),
      .data       (a_data),
      .cnt        (cnt_a),
      .can_accept (a_can)
   );

   demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_b),
      .load_data  (in_data),
      .ready      (b_ready),
      .valid      (b_valid),
      .data       (b_data),
      .cnt        (cnt_b),
      .can_accept (b_can)
   );

endmodule

// File: tb/tb_demux2_buf.sv
// Bench for demux2_buf: queue-based channel model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux2_buf;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_sel = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             a_valid;
   logic             a_ready = 1'b0;
   logic [WIDTH-1:0] a_data;
   logic             b_valid;
   logic             b_ready = 1'b0;
   logic [WIDTH-1:0] b_data;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   int tests = 0;
   int fails = 0;

   demux2_buf #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .cnt_a    (cnt_a),
      .cnt_b    (cnt_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each channel is a queue of words awaiting delivery,
   // the last word written to it, and a saturating delivery count.
   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];
   logic [WIDTH-1:0] last_a = '0;
   logic [WIDTH-1:0] last_b = '0;
   int               dlv_a = 0;
   int               dlv_b = 0;

   function automatic logic model_in_ready();
      if (in_sel) return (qb.size() == 0) || b_ready;
      return (qa.size() == 0) || a_ready;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         last_a = '0;
         last_b = '0;
         dlv_a  = 0;
         dlv_b  = 0;
      end else begin
         logic acc;
         acc = in_valid && model_in_ready();
         if (qa.size() > 0 && a_ready) begin
            void'(qa.pop_front());
            if (dlv_a < CNT_MAX) dlv_a++;
         end
         if (qb.size() > 0 && b_ready) begin
            void'(qb.pop_front());
            if (dlv_b < CNT_MAX) dlv_b++;
         end
         if (acc && !in_sel) begin
            qa.push_back(in_data);
            last_a = in_data;
         end
         if (acc && in_sel) begin
            qb.push_back(in_data);
            last_b = in_data;
         end
      end
   end

   // Compare process, mid-cycle away from the active edge.
   always @(negedge clk) begin
      check("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
      check("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
      check("a_data", a_data, last_a);
      check("b_data", b_data, last_b);
      check("cnt_a", {28'd0, cnt_a}, dlv_a);
      check("cnt_b", {28'd0, cnt_b}, dlv_b);
      check("in_ready", {31'd0, in_ready}, {31'd0, model_in_ready()});
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      rst_n    = 1'b1;
   endtask

   initial begin
      cycle();
      cycle();
      rst_n = 1'b1;
      check("rst a_valid", {31'd0, a_valid}, 32'd0);
      check("rst cnt_a", {28'd0, cnt_a}, 32'd0);

      // basic routing
      a_ready = 1'b1; b_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0000_0000;
      cycle();
      check("route a_valid", {31'd0, a_valid}, 32'd1);
      check("route a_data", a_data, 32'h0000_0000);
      in_sel = 1'b1; in_data = 32'h0000_0001;
      cycle();
      check("route b_valid", {31'd0, b_valid}, 32'd1);
      check("route b_data", b_data, 32'h0000_0001);
      check("route cnt_a", {28'd0, cnt_a}, 32'd1);
      in_valid = 1'b0;
      cycle();
      check("route cnt_b", {28'd0, cnt_b}, 32'd1);

      // back-pressure isolation
      a_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1111_1111;
      cycle();
      in_data = 32'h2222_2222;
      #1;
      check("bp in_ready A", {31'd0, in_ready}, 32'd0);
      cycle();
      check("bp a_data hold", a_data, 32'h1111_1111);
      in_sel = 1'b1; in_data = 32'h3333_3333;
      #1;
      check("bp in_ready B", {31'd0, in_ready}, 32'd1);
      cycle();
      check("bp b_valid", {31'd0, b_valid}, 32'd1);
      check("bp b_data", b_data, 32'h3333_3333);
      check("bp a_data", a_data, 32'h1111_1111);
      check("bp a_valid", {31'd0, a_valid}, 32'd1);
      in_valid = 1'b0; a_ready = 1'b1;
      cycle();
      cycle();

      // full throughput on channel A
      pulse_reset();
      cycle();
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_sel = 1'b0; in_data = i;
         #1;
         check("thru in_ready", {31'd0, in_ready}, 32'd1);
         cycle();
         check("thru a_data", a_data, i);
      end
      in_valid = 1'b0;
      cycle();
      check("thru cnt_a", {28'd0, cnt_a}, 32'd8);

      // drain and load on the same edge
      pulse_reset();
      cycle();
      b_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hAAAA_AAAA;
      cycle();
      check("dl b_data old", b_data, 32'hAAAA_AAAA);
      b_ready = 1'b1; in_data = 32'h5555_5555;
      cycle();
      check("dl b_valid", {31'd0, b_valid}, 32'd1);
      check("dl b_data new", b_data, 32'h5555_5555);
      check("dl cnt_b", {28'd0, cnt_b}, 32'd1);
      in_valid = 1'b0;
      cycle();

      // saturation
      pulse_reset();
      cycle();
      a_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h100 + i;
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      check("sat cnt_a", {28'd0, cnt_a}, 32'd15);
      check("sat cnt_b", {28'd0, cnt_b}, 32'd0);

      // asynchronous reset mid-cycle with both slots full
      a_ready = 1'b0; b_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_0001;
      cycle();
      in_sel = 1'b1; in_data = 32'hDEAD_0002;
      cycle();
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("arst a_valid", {31'd0, a_valid}, 32'd0);
      check("arst b_valid", {31'd0, b_valid}, 32'd0);
      check("arst cnt_a", {28'd0, cnt_a}, 32'd0);
      check("arst cnt_b", {28'd0, cnt_b}, 32'd0);
      check("arst a_data", a_data, 32'd0);
      rst_n = 1'b1;
      cycle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_sel   = $urandom_range(0, 1) != 0;
         in_data  = $urandom;
         a_ready  = ($urandom_range(0, 2) != 0);
         b_ready  = ($urandom_range(0, 3) == 0);
         if (n == 1500) begin
            pulse_reset();
         end
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
